// File: rtl/arb_pkg.sv
// Shared types and default sizing for the round-robin grant controller.
package arb_pkg;
  localparam int N_REQ_DEF    = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic {IDLE, GRANT} arb_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDW-1:0]   rr_ptr_i,
  output logic             any_o,
  output logic [IDW-1:0]   winner_o
);

  logic [IDW-1:0] idx;

  // Scan from farthest to nearest so the candidate closest to rr_ptr_i is written last.
  always_comb begin
    any_o    = |req_i;
    winner_o = '0;
    idx      = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(rr_ptr_i) + i) % N_REQ);
      if (req_i[idx]) winner_o = idx;
    end
  end

endmodule

// File: rtl/rr_grant_controller.sv
// Round-robin owner sequencer for one shared resource: req/gnt/release handshake,
// bounded hold time with forced revoke, one idle cycle between owners.
//
// state | meaning
// IDLE  | no owner; arbitrate pending requests from rr_ptr
// GRANT | one requester owns the resource; hold_cnt runs
module rr_grant_controller
  import arb_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic                     release_i,
  output logic [N_REQ-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_id,
  output logic                     timeout
);

  localparam int IDW = $clog2(N_REQ);
  localparam int HCW = $clog2(MAX_HOLD);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic             to_q, to_d;
  logic             any;
  logic [IDW-1:0]   winner;

  rr_pick #(.N_REQ(N_REQ), .IDW(IDW)) u_pick (
    .req_i    (req),
    .rr_ptr_i (ptr_q),
    .any_o    (any),
    .winner_o (winner)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d       = GRANT;
          gnt_d         = '0;
          gnt_d[winner] = 1'b1;
          id_d          = winner;
          ptr_d         = (winner == IDW'(N_REQ - 1)) ? '0 : winner + IDW'(1);
          hold_d        = '0;
        end
      end
      GRANT: begin
        // A dropped owner request counts as a release, so it also suppresses timeout.
        if (release_i || !req[id_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          hold_d  = '0;
        end else if (hold_q == HCW'(MAX_HOLD - 1)) begin
          state_d = IDLE;
          gnt_d   = '0;
          id_d    = '0;
          hold_d  = '0;
          to_d    = 1'b1;
        end else begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign gnt_id    = id_q;
  assign timeout   = to_q;

  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_grant:  assert property (@(posedge clk) disable iff (!rst_n)
                             (state_q == IDLE && |req) |=> gnt_valid);
  a_cause:  assert property (@(posedge clk) disable iff (!rst_n)
                             (gnt_valid && !$past(gnt_valid)) |-> (($past(req) & gnt) != '0));
  a_hold:   assert property (@(posedge clk) disable iff (!rst_n)
                             gnt_valid |-> (int'(hold_q) < MAX_HOLD));
  a_to:     assert property (@(posedge clk) disable iff (!rst_n) timeout |-> !gnt_valid);
  c_handover: cover property (@(posedge clk) disable iff (!rst_n) $past(gnt[0], 2) && gnt[1]);

endmodule

// File: tb/tb_rr_grant_controller.sv
// Bench for rr_grant_controller: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against an ownership-level reference model.
module tb_rr_grant_controller;
  localparam int N  = 4;
  localparam int MH = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         release_i = 1'b0;
  logic [N-1:0] gnt;
  logic         gnt_valid;
  logic [1:0]   gnt_id;
  logic         timeout;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  rr_grant_controller #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .release_i (release_i),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Reference: who owns the resource, how many cycles it has been visible, next start point.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_to    = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_held  <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_owner < 0) begin
        if (req != '0) begin
          m_owner <= pick(req, m_ptr);
          m_ptr   <= (pick(req, m_ptr) + 1) % N;
          m_held  <= 1;
        end
      end else if (release_i || !req[m_owner]) begin
        m_owner <= -1;
      end else if (m_held == MH) begin
        m_owner <= -1;
        m_to    <= 1'b1;
      end else begin
        m_held <= m_held + 1;
      end
    end
  end

  logic [N-1:0] e_gnt;
  logic [1:0]   e_id;
  always @(negedge clk) begin
    if (chk_on) begin
      e_gnt = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      e_id  = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
      vectors++;
      if (gnt !== e_gnt || gnt_valid !== (m_owner >= 0) || gnt_id !== e_id || timeout !== m_to) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t gnt=%b exp=%b valid=%b id=%0d exp=%0d timeout=%b exp=%b",
                 $time, gnt, e_gnt, gnt_valid, gnt_id, e_id, timeout, m_to);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Apply inputs, let one active edge pass, return 2ns after it.
  task automatic drive(input logic [N-1:0] r, input logic rel);
    req       = r;
    release_i = rel;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    req       = r;
    release_i = 1'b0;
    rst_n     = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      check_lit("rst_gnt", int'(gnt), 0);
      check_lit("rst_id", int'(gnt_id), 0);
      check_lit("rst_timeout", int'(timeout), 0);
    end
    rst_n = 1'b1;
  endtask

  logic [N-1:0] rq;
  logic         rl;
  int           chg_pct, rel_pct;

  initial begin
    @(posedge clk);
    #2;
    chk_on = 1'b1;

    // T1: reset with every request asserted
    do_reset(4'b1111);

    // T2: single requester
    do_reset(4'b0000);
    drive(4'b0100, 1'b0);
    check_lit("t2_gnt", int'(gnt), 4);
    check_lit("t2_id", int'(gnt_id), 2);
    check_lit("t2_model_owner", m_owner, 2);
    drive(4'b0100, 1'b1);
    check_lit("t2_release", int'(gnt), 0);
    drive(4'b0000, 1'b0);

    // T3: fairness with all requesting
    do_reset(4'b0000);
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b0);
      check_lit("t3_order", int'(gnt), 1 << (k % N));
      drive(4'b1111, 1'b1);
      check_lit("t3_gap", int'(gnt), 0);
    end
    drive(4'b0000, 1'b0);

    // T4: forced revoke after MH visible cycles
    do_reset(4'b0000);
    drive(4'b0001, 1'b0);
    check_lit("t4_first", int'(gnt), 1);
    for (int k = 0; k < MH - 1; k++) begin
      drive(4'b0001, 1'b0);
      check_lit("t4_hold", int'(gnt), 1);
      check_lit("t4_no_to", int'(timeout), 0);
    end
    drive(4'b0001, 1'b0);
    check_lit("t4_revoke", int'(gnt), 0);
    check_lit("t4_timeout", int'(timeout), 1);
    check_lit("t4_model_to", int'(m_to), 1);
    drive(4'b0000, 1'b0);
    check_lit("t4_pulse_end", int'(timeout), 0);

    // T5: release coincides with last hold cycle, then wrap from pointer 3
    do_reset(4'b0000);
    drive(4'b0001, 1'b0);
    for (int k = 0; k < MH - 1; k++) drive(4'b0001, 1'b0);
    drive(4'b0001, 1'b1);
    check_lit("t5_collide_gnt", int'(gnt), 0);
    check_lit("t5_collide_to", int'(timeout), 0);
    drive(4'b0100, 1'b0);
    drive(4'b0100, 1'b1);
    check_lit("t5_model_ptr", m_ptr, 3);
    drive(4'b1001, 1'b0);
    check_lit("t5_wrap_3", int'(gnt), 8);
    drive(4'b1001, 1'b1);
    drive(4'b1001, 1'b0);
    check_lit("t5_wrap_0", int'(gnt), 1);
    drive(4'b0000, 1'b1);

    // T6: asynchronous reset in the middle of a grant
    do_reset(4'b0000);
    drive(4'b0100, 1'b0);
    check_lit("t6_pre", int'(gnt), 4);
    #1 rst_n = 1'b0;
    #1;
    check_lit("t6_async_gnt", int'(gnt), 0);
    check_lit("t6_async_valid", int'(gnt_valid), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(4'b0110, 1'b0);
    check_lit("t6_after", int'(gnt), 2);
    check_lit("t6_after_id", int'(gnt_id), 1);
    drive(4'b0000, 1'b0);

    // Randomized traffic: volatile phase, then a calm phase that reaches timeouts
    rq = '0;
    for (int c = 0; c < 600; c++) begin
      chg_pct = (c < 300) ? 25 : 5;
      rel_pct = (c < 300) ? 15 : 4;
      if ($urandom_range(0, 99) < chg_pct) rq = N'($urandom_range(0, 15));
      rl = ($urandom_range(0, 99) < rel_pct);
      drive(rq, rl);
      if (c == 250 || c == 450) begin
        #1 rst_n = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
